// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves branches and jumps, holds one entry under
// backpressure, and drives a registered one-cycle fetch redirect.
module ex_mem_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_less,
  input  logic [4:0]      ex_rd,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic [XLEN-1:0] ex_target,
  input  logic            flush,
  input  logic            mem_ready,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [4:0]      mem_rd,
  output logic [2:0]      mem_funct3,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            mem_misalign,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  logic            mem_valid_q, mem_valid_d;
  logic [XLEN-1:0] mem_result_q, mem_result_d;
  logic [XLEN-1:0] mem_store_data_q, mem_store_data_d;
  logic [4:0]      mem_rd_q, mem_rd_d;
  logic [2:0]      mem_funct3_q, mem_funct3_d;
  logic            mem_reg_write_q, mem_reg_write_d;
  logic            mem_mem_read_q, mem_mem_read_d;
  logic            mem_mem_write_q, mem_mem_write_d;
  logic            mem_misalign_q, mem_misalign_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic            accept, load, cond, taken, misalign;
  logic [XLEN-1:0] target;

  assign ex_ready = !mem_valid_q || mem_ready;
  assign accept   = ex_valid && ex_ready;
  // Instructions arriving while a redirect is visible are on the wrong path.
  assign load     = accept && !redirect_valid_q && !flush;

  always_comb begin
    cond = 1'b0;
    unique case (ex_funct3)
      3'b000:  cond = alu_zero;
      3'b001:  cond = !alu_zero;
      3'b100:  cond = alu_less;
      3'b101:  cond = !alu_less;
      3'b110:  cond = alu_result[0];
      3'b111:  cond = !alu_result[0];
      default: cond = 1'b0;
    endcase
  end

  assign taken    = ex_jal || ex_jalr || (ex_branch && cond);
  assign target   = ex_jalr ? {ex_target[XLEN-1:1], 1'b0} : ex_target;
  assign misalign = taken && (target[1:0] != 2'b00);

  always_comb begin
    mem_valid_d      = mem_valid_q && !mem_ready;
    mem_result_d     = mem_result_q;
    mem_store_data_d = mem_store_data_q;
    mem_rd_d         = mem_rd_q;
    mem_funct3_d     = mem_funct3_q;
    mem_reg_write_d  = mem_reg_write_q;
    mem_mem_read_d   = mem_mem_read_q;
    mem_mem_write_d  = mem_mem_write_q;
    mem_misalign_d   = mem_misalign_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    if (flush) begin
      mem_valid_d    = 1'b0;
      mem_misalign_d = 1'b0;
    end else if (load) begin
      mem_valid_d      = 1'b1;
      mem_result_d     = (ex_jal || ex_jalr) ? ex_pc + 32'd4 : alu_result;
      mem_store_data_d = ex_store_data;
      mem_rd_d         = ex_rd;
      mem_funct3_d     = ex_funct3;
      mem_reg_write_d  = ex_reg_write && !ex_branch && (ex_rd != 5'd0) && !misalign;
      mem_mem_read_d   = ex_mem_read;
      mem_mem_write_d  = ex_mem_write;
      mem_misalign_d   = misalign;
      if (taken && !misalign) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid_q      <= 1'b0;
      mem_result_q     <= '0;
      mem_store_data_q <= '0;
      mem_rd_q         <= '0;
      mem_funct3_q     <= '0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_misalign_q   <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      mem_valid_q      <= mem_valid_d;
      mem_result_q     <= mem_result_d;
      mem_store_data_q <= mem_store_data_d;
      mem_rd_q         <= mem_rd_d;
      mem_funct3_q     <= mem_funct3_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_read_q   <= mem_mem_read_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_misalign_q   <= mem_misalign_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_result     = mem_result_q;
  assign mem_store_data = mem_store_data_q;
  assign mem_rd         = mem_rd_q;
  assign mem_funct3     = mem_funct3_q;
  assign mem_reg_write  = mem_reg_write_q;
  assign mem_mem_read   = mem_mem_read_q;
  assign mem_mem_write  = mem_mem_write_q;
  assign mem_misalign   = mem_misalign_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ex_valid  input  1  execute-stage instruction present.
REQ-005 ex_ready  output  1  stage can accept this cycle (combinational).
REQ-006 ex_pc  input  32  PC of the execute-stage instruction.
REQ-007 alu_result  input  32  ALU result.
REQ-008 alu_zero  input  1  ALU zero flag.
REQ-009 alu_less  input  1  ALU signed-less flag.
REQ-010 ex_rd, ex_funct3, ex_store_data  input  5/3/32  destination register, funct3, rs2 store data.
REQ-011 ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jal, ex_jalr  input  1 each  decoded controls.
REQ-012 ex_target  input  32  branch/jump target computed upstream.
REQ-013 flush  input  1  trap flush, highest priority.
REQ-014 mem_ready  input  1  memory stage accepts the held entry.
REQ-015 mem_valid, mem_result, mem_store_data, mem_rd, mem_funct3  output  1/32/32/5/3  registered entry.
REQ-016 mem_reg_write, mem_mem_read, mem_mem_write, mem_misalign  output  1 each  registered controls and exception flag.
REQ-017 redirect_valid, redirect_pc  output  1/32  registered one-cycle fetch redirect.

Function
REQ-018 ex_ready SHALL be !mem_valid || mem_ready; accept = ex_valid && ex_ready.
REQ-019 On accept, all mem_* fields SHALL load on the next edge with mem_valid=1 (latency 1).
REQ-020 If mem_valid && mem_ready && !accept, mem_valid SHALL clear; mem_* data SHALL hold while mem_valid && !mem_ready.
REQ-021 Branch condition by ex_funct3 (ALU set to SUB for 000/001/100/101, SLTU for 110/111): 000 alu_zero; 001 !alu_zero; 100 alu_less; 101 !alu_less; 110 alu_result[0]; 111 !alu_result[0]; 010/011 never taken.
REQ-022 taken = ex_jal || ex_jalr || (ex_branch && condition); target = ex_jalr ? {ex_target[31:1],1'b0} : ex_target.
REQ-023 On accept with taken and target[1:0]==0, redirect_valid SHALL be 1 and redirect_pc = target for exactly the next cycle, independent of mem_ready.
REQ-024 On accept with taken and target[1:0]!=0, SHALL set mem_misalign=1, mem_reg_write=0, and no redirect.
REQ-025 For ex_jal/ex_jalr, mem_result SHALL be ex_pc+4 (mod 2^32); otherwise alu_result.
REQ-026 For ex_branch, mem_reg_write SHALL be 0; ex_rd==0 SHALL force mem_reg_write=0.
REQ-027 In any cycle with redirect_valid=1, an accepted instruction SHALL be discarded (wrong path): no mem_valid set, no redirect, ex_ready still as REQ-018.
REQ-028 flush=1 SHALL clear mem_valid, redirect_valid and mem_misalign on the next edge and discard any same-cycle accept; flush overrides accept, redirect and squash.
REQ-029 Simultaneous accept and mem_ready on a valid entry SHALL replace the entry with no bubble.
REQ-030 No combinational path SHALL exist from alu_* to any output except via registers; ex_ready depends only on mem_valid, mem_ready.

Reset
REQ-031 With rst_n=0 at an edge, all outputs SHALL be 0 on the next cycle, including redirect_pc and mem_result; ex_ready SHALL read 1 after reset.
REQ-032 Reset mid-stall or during a redirect pulse SHALL discard the entry/pulse with no residual output.

Verification
REQ-033 BEQ, funct3=000, alu_zero=1, ex_target=0x0000_0100 -> next cycle redirect_valid=1, redirect_pc=0x100, mem_reg_write=0; following cycle redirect_valid=0.
REQ-034 JALR, ex_pc=0x0000_0040, ex_target=0x0000_0205, rd=1 -> redirect_pc=0x204, mem_result=0x44, mem_reg_write=1.
REQ-035 Taken BNE to 0x0000_0102 -> mem_misalign=1, redirect_valid=0.
REQ-036 mem_ready=0 with entry held, ADD result 0x0000_0007 offered -> ex_ready=0, mem_result stays old value; mem_ready=1 -> 0x7 loads next edge.
REQ-037 Redirect cycle with ex_valid=1 -> instruction dropped, mem_valid=0 next cycle; flush=1 with ex_valid=1 -> mem_valid=0, redirect_valid=0.
REQ-038 rst_n=0 while mem_valid=1, mem_ready=0 -> all outputs 0 next cycle, ex_ready=1.
